// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble (shift-and-add-3) binary to BCD converter.
// One input bit is consumed per clock, so a conversion takes BIN_W cycles.
// It uses a start/busy/done handshake and holds the last result on bcd_out.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  // Decimal digit count of 2^bits-1: floor(bits*log10(2))+1, since 2^bits is never a power of ten.
  function automatic int unsigned dec_digits_needed(input int unsigned bits);
    longint unsigned scaled;
    scaled = 64'(bits) * 64'd30103;
    return 32'(scaled / 64'd100000) + 32'd1;
  endfunction

  localparam int unsigned DIGITS_MIN = dec_digits_needed(BIN_W);

  // Refuse to elaborate when the largest input cannot be represented in DIGITS digits.
  generate
    if (BIN_W < 1 || DIGITS < DIGITS_MIN) begin : g_param_err
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W (need 10^DIGITS > 2^BIN_W-1)");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [SCR_W-1:0]   bcd_q,     bcd_d;
  logic [BIN_W-1:0]   shift_q,   shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_shl;

  // Add-3 correction: every scratch digit >= 5 is bumped so the following doubling carries correctly.
  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Shift left by one: the binary MSB enters the units digit and the scratch MSB (always 0) drops off.
  assign scratch_shl = SCR_W'({scratch_adj, shift_q[BIN_W-1]});

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = scratch_shl;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bcd_d   = scratch_shl;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any conversion without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int n_cmp;
  int n_bad;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit nibbles_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // One conversion: start at the next edge, scramble bin_in meanwhile, wait bounded for done.
  task automatic do_convert(input int v, input bit verbose);
    int  n;
    bit  seen;
    bit  busy_ok;
    start  = 1'b1;
    bin_in = 8'(v);
    step();
    start  = 1'b0;
    bin_in = ~8'(v);
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && n < 20) begin
      step();
      n++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk_eq($sformatf("conv%0d_done", v), 32'(seen), 32'd1);
    chk_eq($sformatf("conv%0d_bcd", v), 32'(bcd_out), 32'(ref_bcd(v)));
    if (verbose) begin
      chk_eq($sformatf("conv%0d_latency", v), 32'(n), 32'd8);
      chk_eq($sformatf("conv%0d_busy_low_at_done", v), 32'(busy), 32'd0);
      chk_eq($sformatf("conv%0d_busy_during", v), 32'(busy_ok), 32'd1);
    end else begin
      chk_eq($sformatf("conv%0d_nibbles", v), 32'(nibbles_ok(bcd_out)), 32'd1);
    end
  endtask

  initial begin
    int  ndone;
    int  first_k;
    bit  flag_a;
    bit  flag_b;
    bit  flag_c;

    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    flag_a = 1'b1;
    flag_b = 1'b1;
    flag_c = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0) flag_a = 1'b0;
      if (done !== 1'b0) flag_b = 1'b0;
      if (bcd_out !== 12'h000) flag_c = 1'b0;
    end
    chk_eq("idle_busy", 32'(busy), 32'd0);
    chk_eq("idle_done", 32'(done), 32'd0);
    chk_eq("idle_bcd", 32'(bcd_out), 32'h000);
    chk_eq("idle_busy_all", 32'(flag_a), 32'd1);
    chk_eq("idle_done_all", 32'(flag_b), 32'd1);
    chk_eq("idle_bcd_all", 32'(flag_c), 32'd1);

    // Single conversions.
    do_convert(0, 1'b1);
    chk_eq("fixed_0", 32'(bcd_out), 32'h000);
    do_convert(59, 1'b1);
    chk_eq("fixed_59", 32'(bcd_out), 32'h059);
    do_convert(99, 1'b1);
    chk_eq("fixed_99", 32'(bcd_out), 32'h099);
    do_convert(255, 1'b1);
    chk_eq("fixed_255", 32'(bcd_out), 32'h255);
    step();
    chk_eq("done_one_cycle", 32'(done), 32'd0);
    chk_eq("bcd_holds", 32'(bcd_out), 32'h255);

    // Start while busy is ignored.
    start  = 1'b1;
    bin_in = 8'd23;
    step();
    start  = 1'b0;
    ndone  = 0;
    first_k = -1;
    flag_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin
        start  = 1'b1;
        bin_in = 8'd200;
      end else begin
        start  = 1'b0;
      end
      step();
      if (done) begin
        ndone++;
        if (first_k < 0) first_k = k;
        if (bcd_out !== 12'h023) flag_a = 1'b0;
      end
      if (bcd_out == 12'h200) flag_a = 1'b0;
    end
    chk_eq("busy_start_ndone", 32'(ndone), 32'd1);
    chk_eq("busy_start_cycle", 32'(first_k), 32'd8);
    chk_eq("busy_start_bcd", 32'(bcd_out), 32'h023);
    chk_eq("busy_start_no200", 32'(flag_a), 32'd1);

    // Back-to-back with start held high.
    start  = 1'b1;
    bin_in = 8'd12;
    step();
    ndone  = 0;
    flag_a = 1'b1;
    flag_b = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (busy === done) flag_a = 1'b0;
      if (done) begin
        ndone++;
        if (k == 8) begin
          if (bcd_out !== 12'h012) flag_b = 1'b0;
          bin_in = 8'd47;
        end else if (k == 17) begin
          if (bcd_out !== 12'h047) flag_b = 1'b0;
        end else begin
          flag_b = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk_eq("b2b_ndone", 32'(ndone), 32'd2);
    chk_eq("b2b_results", 32'(flag_b), 32'd1);
    chk_eq("b2b_busy_pattern", 32'(flag_a), 32'd1);
    chk_eq("b2b_last_bcd", 32'(bcd_out), 32'h047);
    step();

    // Reset mid-conversion.
    start  = 1'b1;
    bin_in = 8'd200;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    chk_eq("midrst_bcd", 32'(bcd_out), 32'h000);
    flag_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 12'h000) flag_a = 1'b0;
    end
    chk_eq("midrst_quiet", 32'(flag_a), 32'd1);
    do_convert(7, 1'b1);
    chk_eq("midrst_then_7", 32'(bcd_out), 32'h007);

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      do_convert(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from a binary count to packed BCD digits.
- Sits upstream of the 7-segment digit decoders in the clock datapath.
- Turns binary hour/minute/second or counter values into per-digit BCD nibbles, one nibble per display digit.
- One conversion takes BIN_W clock cycles, with a start/busy/done handshake.

Parameters:
- BIN_W, 8, width of the binary input in bits (minimum 1).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration fails (generate-time error) otherwise.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when busy=0.
- bin_in  input  BIN_W  unsigned binary value; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd_out holds a new result.
- bcd_out  output  4*DIGITS  packed BCD. Digit 0 (units) is in [3:0], digit k is in [4k+3:4k]. Every nibble is 0..9.

Behaviour:
- Reset, synchronous: when rst=1 at a rising edge, the following registers clear and any conversion in progress is aborted with no done pulse:
  - state=IDLE, busy=0, done=0, bcd_out=0
  - internal shift register, scratch BCD, iteration counter = 0
- rst has priority over start.
- State IDLE, busy=0:
  - start=1 at edge E0 accepts a request.
  - Load shift register with bin_in, clear scratch BCD, set counter=0, busy=1, go to CONV.
  - start=0: remain in IDLE.
- State CONV, busy=1. Each edge performs one iteration:
  - Every scratch digit >=5 gets +3, all digits in parallel, combinationally.
  - Then {scratch, shift register} shifts left by 1: the shift register MSB enters scratch bit 0, and scratch MSB is discarded (it is guaranteed 0 by the parameter rule).
  - counter increments.
- Final iteration, edge E_BIN_W (counter == BIN_W-1 before the edge):
  - bcd_out <= post-shift scratch, done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at E0 gives done=1 and a valid bcd_out in the cycle after edge E_BIN_W. That is exactly BIN_W cycles; BIN_W=8 gives 8 cycles.
- done is high for exactly one cycle and deasserts at the next edge unless that edge completes another conversion.
- bcd_out is registered, changes only on the edge that raises done, and holds its value between conversions.
- start while busy=1 is ignored; it is neither queued nor restarts the conversion. bin_in changes during CONV have no effect.
- Back-to-back: in the done cycle busy=0, so start=1 in that cycle is accepted at the next edge. Sustained throughput is one result per BIN_W+1 cycles.
- start held high continuously: a new conversion begins on every edge where busy=0.
- Maximum input 2^BIN_W-1 converts without truncation. BIN_W=8, DIGITS=3 gives 255 -> 0x255.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 20 cycles -> busy=0, done=0, bcd_out=0x000 throughout.
- Single conversions (BIN_W=8, DIGITS=3); each must take exactly 8 cycles from the start edge to done:
  - bin_in=0 -> bcd_out=0x000
  - bin_in=59 -> 0x059
  - bin_in=99 -> 0x099
  - bin_in=255 -> 0x255
- Start during busy: start=1 with bin_in=23, then at cycle 3 start=1 with bin_in=200 -> only one done pulse at cycle 8, bcd_out=0x023. Result of 200 never appears.
- Back-to-back: start held high, bin_in=12 then 47, switched in the done cycle -> done pulses at cycles 8 and 17, bcd_out=0x012 then 0x047. busy low only in the done cycles.
- Reset mid-conversion: start with bin_in=200, rst=1 at cycle 4 -> no done pulse, bcd_out=0x000, busy=0. A following start with bin_in=7 -> 0x007 after 8 cycles.
- Exhaustive sweep: bin_in=0..255 sequentially -> every result matches the reference model (digits = value/100, (value/10)%10, value%10), and every nibble is <=9.
